// File: rtl/hd44780_pkg.sv
// Shared opcodes, DDRAM geometry, bus FSM states and the address-counter
// stepping helper for the HD44780 device-side responder.
package hd44780_pkg;

    localparam logic [7:0] OP_CLEAR_MASK     = 8'hFF;
    localparam logic [7:0] OP_CLEAR          = 8'h01;
    localparam logic [7:0] OP_HOME_MASK      = 8'hFE;
    localparam logic [7:0] OP_HOME           = 8'h02;
    localparam logic [7:0] OP_ENTRY_MASK     = 8'hFC;
    localparam logic [7:0] OP_ENTRY          = 8'h04;
    localparam logic [7:0] OP_SET_DDRAM_MASK = 8'h80;
    localparam logic [7:0] OP_SET_DDRAM      = 8'h80;

    localparam int         DDRAM_DEPTH = 80;
    localparam logic [6:0] DDRAM_LAST  = 7'h4F;
    localparam logic [7:0] BLANK_CHAR  = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_HIGH,
        ST_RD_HIGH
    } busState_t;

    // The address counter only ever covers 0x00..0x4F, wrapping at both ends.
    function automatic logic [6:0] acStep(input logic [6:0] cur, input logic incr);
        if (incr) begin
            return (cur == DDRAM_LAST) ? 7'd0 : cur + 7'd1;
        end
        return (cur == 7'd0) ? DDRAM_LAST : cur - 7'd1;
    endfunction

endpackage

// File: rtl/hd44780_ddram.sv
// 80 x 8 display data RAM: one synchronous write port, asynchronous read.
// Contents are deliberately not reset, like the real controller.
module hd44780_ddram
    import hd44780_pkg::*;
(
    input  logic       clk,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [DDRAM_DEPTH];

    // Single write port shared by bus writes and the clear walk upstream
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/hd44780_lcd_responder.sv
// Device-side model of the HD44780U 8-bit parallel bus: decodes instructions,
// holds DDRAM and the address counter, answers reads, models busy time and
// flags bus timing violations with sticky error bits.
module hd44780_lcd_responder
    import hd44780_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int EXEC_CYCLES      = 3700,
    parameter int CLEAR_CYCLES     = 152000,
    parameter int MIN_SETUP_CYCLES = 4,
    parameter int MIN_EPW_CYCLES   = 40
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  rs,
    input  logic                  rwb,
    input  logic                  e,
    input  logic [DATA_WIDTH-1:0] dq_in,
    output logic [DATA_WIDTH-1:0] dq_out,
    output logic                  dq_oe,
    output logic                  busy,
    output logic [6:0]            ac,
    output logic                  mon_valid,
    output logic                  mon_rs,
    output logic [DATA_WIDTH-1:0] mon_data,
    output logic                  err_busy,
    output logic                  err_pw,
    output logic                  err_setup,
    input  logic                  err_clr
);

    localparam int BW = $clog2(CLEAR_CYCLES + 1);
    localparam int SW = $clog2(MIN_SETUP_CYCLES + 1);
    localparam int PW = $clog2(MIN_EPW_CYCLES + 1);

    logic                  r_eQ, r_rsQ, r_rwbQ;
    logic [DATA_WIDTH-1:0] r_dqQ;
    busState_t             r_state;
    logic                  r_dqOe;
    logic [DATA_WIDTH-1:0] r_dqOut;
    logic [BW-1:0]         r_busyCnt;
    logic [SW-1:0]         r_stableCnt;
    logic [PW-1:0]         r_pwCnt;
    logic                  r_incr;
    logic [6:0]            r_ac;
    logic                  r_walkActive;
    logic [6:0]            r_walkAddr;
    logic                  r_monValid, r_monRs;
    logic [DATA_WIDTH-1:0] r_monData;
    logic                  r_errBusy, r_errPw, r_errSetup;

    logic       w_rise, w_fall, w_busyNow, w_ctrlChange;
    logic       w_commitWr, w_acceptWr, w_dataWr, w_instrWr, w_dataRd;
    logic       w_setupErr, w_pwErr;
    logic       w_isClear, w_isHome, w_isEntry, w_isSetDdram;
    logic       w_ramWe;
    logic [6:0] w_ramAddr;
    logic [7:0] w_ramWdata, w_ramRdata;

    assign w_rise       = e & ~r_eQ;
    assign w_fall       = ~e & r_eQ & (r_state != ST_IDLE);
    assign w_busyNow    = (r_busyCnt != '0);
    assign w_ctrlChange = (rs != r_rsQ) | (rwb != r_rwbQ);

    assign w_commitWr = w_fall & ~r_rwbQ;
    assign w_acceptWr = w_commitWr & ~w_busyNow;
    assign w_dataWr   = w_acceptWr & r_rsQ;
    assign w_instrWr  = w_acceptWr & ~r_rsQ;
    assign w_dataRd   = w_fall & r_rwbQ & r_rsQ;

    assign w_setupErr = (w_rise & (w_ctrlChange | (r_stableCnt < SW'(MIN_SETUP_CYCLES - 1))))
                      | (e & r_eQ & w_ctrlChange);
    assign w_pwErr    = w_fall & (r_pwCnt < PW'(MIN_EPW_CYCLES));

    assign w_isClear    = (r_dqQ[7:0] & OP_CLEAR_MASK) == OP_CLEAR;
    assign w_isHome     = (r_dqQ[7:0] & OP_HOME_MASK) == OP_HOME;
    assign w_isEntry    = (r_dqQ[7:0] & OP_ENTRY_MASK) == OP_ENTRY;
    assign w_isSetDdram = (r_dqQ[7:0] & OP_SET_DDRAM_MASK) == OP_SET_DDRAM;

    assign w_ramWe    = r_walkActive | w_dataWr;
    assign w_ramAddr  = r_walkActive ? r_walkAddr : r_ac;
    assign w_ramWdata = r_walkActive ? BLANK_CHAR : r_dqQ[7:0];

    hd44780_ddram u_ddram (
        .clk     (clk),
        .i_we    (w_ramWe),
        .i_waddr (w_ramAddr),
        .i_wdata (w_ramWdata),
        .i_raddr (r_ac),
        .o_rdata (w_ramRdata)
    );

    // Register the bus every cycle so edges and commits see a stable snapshot
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_eQ   <= 1'b0;
            r_rsQ  <= 1'b0;
            r_rwbQ <= 1'b0;
            r_dqQ  <= '0;
        end else begin
            r_eQ   <= e;
            r_rsQ  <= rs;
            r_rwbQ <= rwb;
            r_dqQ  <= dq_in;
        end
    end

    // Bus FSM: read data is latched at rise and driven until one cycle past fall
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
            r_dqOe  <= 1'b0;
            r_dqOut <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise && rwb) begin
                        r_state <= ST_RD_HIGH;
                        r_dqOe  <= 1'b1;
                        r_dqOut <= rs ? w_ramRdata : {w_busyNow, r_ac};
                    end else begin
                        r_dqOe <= 1'b0;
                        if (w_rise) begin
                            r_state <= ST_WR_HIGH;
                        end
                    end
                end
                ST_WR_HIGH: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_HIGH: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Instruction execution: address counter, entry mode, busy time, clear walk
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ac         <= 7'd0;
            r_incr       <= 1'b1;
            r_busyCnt    <= '0;
            r_walkActive <= 1'b0;
            r_walkAddr   <= 7'd0;
        end else begin
            if (w_instrWr && (w_isClear || w_isHome)) begin
                r_busyCnt <= BW'(CLEAR_CYCLES);
            end else if (w_acceptWr) begin
                r_busyCnt <= BW'(EXEC_CYCLES);
            end else if (w_busyNow) begin
                r_busyCnt <= r_busyCnt - 1'b1;
            end

            if (w_instrWr) begin
                if (w_isClear || w_isHome) begin
                    r_ac <= 7'd0;
                end else if (w_isSetDdram) begin
                    r_ac <= (r_dqQ[6:0] > DDRAM_LAST) ? 7'd0 : r_dqQ[6:0];
                end
            end else if (w_dataWr || w_dataRd) begin
                r_ac <= acStep(r_ac, r_incr);
            end

            if (w_instrWr && w_isClear) begin
                r_incr <= 1'b1;
            end else if (w_instrWr && w_isEntry) begin
                r_incr <= r_dqQ[1];
            end

            if (w_instrWr && w_isClear) begin
                r_walkActive <= 1'b1;
                r_walkAddr   <= 7'd0;
            end else if (r_walkActive) begin
                r_walkAddr <= r_walkAddr + 7'd1;
                if (r_walkAddr == DDRAM_LAST) begin
                    r_walkActive <= 1'b0;
                end
            end
        end
    end

    // Timing monitors: control stability before rise and enable pulse width
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_stableCnt <= '0;
            r_pwCnt     <= '0;
        end else begin
            if (w_ctrlChange) begin
                r_stableCnt <= '0;
            end else if (r_stableCnt < SW'(MIN_SETUP_CYCLES)) begin
                r_stableCnt <= r_stableCnt + 1'b1;
            end

            if (w_rise) begin
                r_pwCnt <= PW'(1);
            end else if (e && r_eQ && (r_pwCnt < PW'(MIN_EPW_CYCLES))) begin
                r_pwCnt <= r_pwCnt + 1'b1;
            end
        end
    end

    // Sticky error flags; a new violation wins over a simultaneous clear
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_errBusy  <= 1'b0;
            r_errPw    <= 1'b0;
            r_errSetup <= 1'b0;
        end else begin
            r_errBusy  <= (w_commitWr & w_busyNow) | (r_errBusy & ~err_clr);
            r_errPw    <= w_pwErr | (r_errPw & ~err_clr);
            r_errSetup <= w_setupErr | (r_errSetup & ~err_clr);
        end
    end

    // Write monitor pulses for every committed write, including dropped ones
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_monValid <= 1'b0;
            r_monRs    <= 1'b0;
            r_monData  <= '0;
        end else begin
            r_monValid <= w_commitWr;
            if (w_commitWr) begin
                r_monRs   <= r_rsQ;
                r_monData <= r_dqQ;
            end
        end
    end

    assign dq_out    = r_dqOut;
    assign dq_oe     = r_dqOe;
    assign busy      = w_busyNow;
    assign ac        = r_ac;
    assign mon_valid = r_monValid;
    assign mon_rs    = r_monRs;
    assign mon_data  = r_monData;
    assign err_busy  = r_errBusy;
    assign err_pw    = r_errPw;
    assign err_setup = r_errSetup;

endmodule

// File: tb/tb_hd44780_lcd_responder.sv
// Directed bench for the HD44780 responder with shortened busy times so the
// clear walk and busy-boundary cases run quickly.
module tb_hd44780_lcd_responder;

    localparam int EXEC  = 100;
    localparam int CLEAR = 400;

    logic       clk = 1'b0;
    logic       nrst, rs, rwb, e, err_clr;
    logic [7:0] dq_in;
    logic [7:0] dq_out, mon_data;
    logic [6:0] ac;
    logic       dq_oe, busy, mon_valid, mon_rs, err_busy, err_pw, err_setup;

    int checks = 0;
    int passes = 0;
    int oeCount = 0;

    hd44780_lcd_responder #(
        .DATA_WIDTH       (8),
        .EXEC_CYCLES      (EXEC),
        .CLEAR_CYCLES     (CLEAR),
        .MIN_SETUP_CYCLES (4),
        .MIN_EPW_CYCLES   (40)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .rs        (rs),
        .rwb       (rwb),
        .e         (e),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .busy      (busy),
        .ac        (ac),
        .mon_valid (mon_valid),
        .mon_rs    (mon_rs),
        .mon_data  (mon_data),
        .err_busy  (err_busy),
        .err_pw    (err_pw),
        .err_setup (err_setup),
        .err_clr   (err_clr)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Count cycles in which the responder drives the bus
    always @(negedge clk) begin
        if (dq_oe === 1'b1) oeCount++;
    end

    // Hard stop in case something wedges
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1, "[TB] watchdog");
    end

    // One bus access: controls set after a posedge, held `setup` cycles, then e high `width` cycles
    task automatic applyStimulus(input logic iRs, input logic iRwb, input logic [7:0] iData,
                                 input int setup, input int width);
        @(posedge clk); #1;
        rs = iRs; rwb = iRwb; dq_in = iData;
        repeat (setup) @(posedge clk);
        #1 e = 1'b1;
        repeat (width) @(posedge clk);
        #1 e = 1'b0;
    endtask

    // Advance to the sampling point just after the fall edge of the last access
    task automatic afterFall;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Bounded wait for the busy flag to drop
    task automatic waitIdle;
        int n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("[TB] FAIL wait_idle: busy=%b want 0 after %0d cycles", busy, n);
        else passes++;
    endtask

    // Count negedges with busy high, starting from the current sample point
    task automatic busyLen(output int n);
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic clearErrors;
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        nrst = 1'b0; rs = 1'b0; rwb = 1'b0; e = 1'b0; err_clr = 1'b0; dq_in = 8'h00;
        #22;
        checks++; if ({dq_oe, busy, mon_valid, mon_rs} !== 4'b0000) $display("[TB] FAIL reset_flags: got %b want 0000", {dq_oe, busy, mon_valid, mon_rs}); else passes++;
        checks++; if (ac !== 7'h00) $display("[TB] FAIL reset_ac: got %h want 00", ac); else passes++;
        checks++; if ({dq_out, mon_data} !== 16'h0000) $display("[TB] FAIL reset_data: got %h want 0000", {dq_out, mon_data}); else passes++;
        checks++; if ({err_busy, err_pw, err_setup} !== 3'b000) $display("[TB] FAIL reset_err: got %b want 000", {err_busy, err_pw, err_setup}); else passes++;
        @(negedge clk); nrst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_data;
        int n;
        applyStimulus(1'b0, 1'b0, 8'h80, 8, 42);
        afterFall;
        checks++; if ({mon_valid, mon_rs} !== 2'b10) $display("[TB] FAIL instr_mon: got %b want 10", {mon_valid, mon_rs}); else passes++;
        checks++; if (mon_data !== 8'h80) $display("[TB] FAIL instr_mon_data: got %h want 80", mon_data); else passes++;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL instr_busy: got %b want 1", busy); else passes++;
        busyLen(n);
        checks++; if (n != EXEC) $display("[TB] FAIL exec_busy_len: got %0d want %0d", n, EXEC); else passes++;
        applyStimulus(1'b1, 1'b0, 8'h41, 8, 42);
        afterFall;
        checks++; if (ac !== 7'h01) $display("[TB] FAIL data1_ac: got %h want 01", ac); else passes++;
        checks++; if ({mon_rs, mon_data} !== 9'h141) $display("[TB] FAIL data1_mon: got %h want 141", {mon_rs, mon_data}); else passes++;
        waitIdle;
        applyStimulus(1'b1, 1'b0, 8'h42, 8, 42);
        afterFall;
        checks++; if ({busy, ac} !== 8'h82) $display("[TB] FAIL data2_ac: got %h want 82", {busy, ac}); else passes++;
    endtask

    task automatic test_read_busy;
        oeCount = 0;
        applyStimulus(1'b0, 1'b1, 8'h00, 8, 42);
        @(negedge clk);
        checks++; if (dq_out !== 8'h82) $display("[TB] FAIL bf_read: got %h want 82", dq_out); else passes++;
        checks++; if (dq_oe !== 1'b1) $display("[TB] FAIL bf_oe_high: got %b want 1", dq_oe); else passes++;
        @(negedge clk);
        checks++; if (dq_oe !== 1'b1) $display("[TB] FAIL bf_oe_hold: got %b want 1", dq_oe); else passes++;
        @(negedge clk);
        checks++; if (dq_oe !== 1'b0) $display("[TB] FAIL bf_oe_release: got %b want 0", dq_oe); else passes++;
        @(negedge clk);
        checks++; if (oeCount != 43) $display("[TB] FAIL bf_oe_len: got %0d want 43", oeCount); else passes++;
        checks++; if (ac !== 7'h02) $display("[TB] FAIL bf_ac: got %h want 02", ac); else passes++;
        waitIdle;
        applyStimulus(1'b0, 1'b0, 8'h80, 8, 42);
        afterFall;
        applyStimulus(1'b1, 1'b1, 8'h00, 8, 42);
        @(negedge clk);
        checks++; if (dq_out !== 8'h41) $display("[TB] FAIL rd_ddram0: got %h want 41", dq_out); else passes++;
        applyStimulus(1'b1, 1'b1, 8'h00, 8, 42);
        @(negedge clk);
        checks++; if (dq_out !== 8'h42) $display("[TB] FAIL rd_ddram1: got %h want 42", dq_out); else passes++;
        afterFall;
        checks++; if (ac !== 7'h02) $display("[TB] FAIL rd_ac: got %h want 02", ac); else passes++;
    endtask

    task automatic test_wrap;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h04, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'hCF, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b1, 1'b0, 8'h66, 8, 42); afterFall;
        checks++; if (ac !== 7'h4E) $display("[TB] FAIL dec_ac: got %h want 4e", ac); else passes++;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h80, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b1, 1'b0, 8'h55, 8, 42); afterFall;
        checks++; if (ac !== 7'h4F) $display("[TB] FAIL dec_wrap: got %h want 4f", ac); else passes++;
        waitIdle;
        applyStimulus(1'b1, 1'b1, 8'h00, 8, 42);
        @(negedge clk);
        checks++; if (dq_out !== 8'h66) $display("[TB] FAIL rd_4f: got %h want 66", dq_out); else passes++;
        afterFall;
        checks++; if (ac !== 7'h4E) $display("[TB] FAIL rd_dec_ac: got %h want 4e", ac); else passes++;
        applyStimulus(1'b0, 1'b0, 8'hD5, 8, 42); afterFall;
        checks++; if (ac !== 7'h00) $display("[TB] FAIL setdd_range: got %h want 00", ac); else passes++;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h06, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'hCF, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b1, 1'b0, 8'h77, 8, 42); afterFall;
        checks++; if (ac !== 7'h00) $display("[TB] FAIL inc_wrap: got %h want 00", ac); else passes++;
    endtask

    task automatic test_clear;
        int n;
        int bad = 0;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h04, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h85, 8, 42); afterFall;
        waitIdle; applyStimulus(1'b0, 1'b0, 8'h01, 8, 42); afterFall;
        checks++; if ({busy, ac} !== 8'h80) $display("[TB] FAIL clear_ac: got %h want 80", {busy, ac}); else passes++;
        busyLen(n);
        checks++; if (n != CLEAR) $display("[TB] FAIL clear_busy_len: got %0d want %0d", n, CLEAR); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h80, 8, 42);
        afterFall;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'b1, 1'b1, 8'h00, 8, 40);
            @(negedge clk);
            if (dq_out !== 8'h20) bad++;
        end
        afterFall;
        checks++; if (bad != 0) $display("[TB] FAIL clear_fill: got %0d non-blank bytes want 0", bad); else passes++;
        checks++; if (ac !== 7'h00) $display("[TB] FAIL clear_incr_wrap: got %h want 00", ac); else passes++;
    endtask

    task automatic test_write_while_busy;
        waitIdle;
        checks++; if (err_busy !== 1'b0) $display("[TB] FAIL errbusy_pre: got %b want 0", err_busy); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h83, 8, 42);
        applyStimulus(1'b1, 1'b0, 8'h33, 8, 42);
        afterFall;
        checks++; if ({mon_valid, mon_rs, mon_data} !== 10'h333) $display("[TB] FAIL drop_mon: got %h want 333", {mon_valid, mon_rs, mon_data}); else passes++;
        checks++; if (err_busy !== 1'b1) $display("[TB] FAIL drop_err: got %b want 1", err_busy); else passes++;
        checks++; if (ac !== 7'h03) $display("[TB] FAIL drop_ac: got %h want 03", ac); else passes++;
        clearErrors;
        checks++; if (err_busy !== 1'b0) $display("[TB] FAIL err_clr: got %b want 0", err_busy); else passes++;
        waitIdle;
        applyStimulus(1'b1, 1'b1, 8'h00, 8, 42);
        @(negedge clk);
        checks++; if (dq_out !== 8'h20) $display("[TB] FAIL drop_ddram: got %h want 20", dq_out); else passes++;
        afterFall;
    endtask

    task automatic test_back_to_back;
        waitIdle;
        applyStimulus(1'b0, 1'b0, 8'h90, 8, 42);
        applyStimulus(1'b1, 1'b0, 8'h44, 8, 91);
        afterFall;
        checks++; if (err_busy !== 1'b1) $display("[TB] FAIL last_busy_err: got %b want 1", err_busy); else passes++;
        checks++; if (ac !== 7'h10) $display("[TB] FAIL last_busy_ac: got %h want 10", ac); else passes++;
        clearErrors;
        waitIdle;
        applyStimulus(1'b0, 1'b0, 8'h90, 8, 42);
        applyStimulus(1'b1, 1'b0, 8'h44, 8, 92);
        afterFall;
        checks++; if (err_busy !== 1'b0) $display("[TB] FAIL first_free_err: got %b want 0", err_busy); else passes++;
        checks++; if (ac !== 7'h11) $display("[TB] FAIL first_free_ac: got %h want 11", ac); else passes++;
    endtask

    task automatic test_timing_errors;
        waitIdle;
        checks++; if ({err_setup, err_pw} !== 2'b00) $display("[TB] FAIL timing_pre: got %b want 00", {err_setup, err_pw}); else passes++;
        applyStimulus(1'b0, 1'b0, 8'h8A, 8, 42); afterFall;
        waitIdle;
        applyStimulus(1'b1, 1'b0, 8'h5A, 2, 10);
        afterFall;
        checks++; if (err_setup !== 1'b1) $display("[TB] FAIL setup_err: got %b want 1", err_setup); else passes++;
        checks++; if (err_pw !== 1'b1) $display("[TB] FAIL pw_err: got %b want 1", err_pw); else passes++;
        checks++; if ({ac, mon_data} !== 15'h0B5A) $display("[TB] FAIL bad_timing_commit: got %h want 0b5a", {ac, mon_data}); else passes++;
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1 rs = 1'b1; rwb = 1'b1;
        repeat (8) @(posedge clk);
        #1 e = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if ({dq_oe, busy} !== 2'b11) $display("[TB] FAIL mid_pre: got %b want 11", {dq_oe, busy}); else passes++;
        #1 nrst = 1'b0;
        #1;
        checks++; if ({dq_oe, busy, mon_valid, mon_rs} !== 4'b0000) $display("[TB] FAIL mid_rst_flags: got %b want 0000", {dq_oe, busy, mon_valid, mon_rs}); else passes++;
        checks++; if ({ac, dq_out, mon_data} !== 23'h0) $display("[TB] FAIL mid_rst_data: got %h want 0", {ac, dq_out, mon_data}); else passes++;
        checks++; if ({err_busy, err_pw, err_setup} !== 3'b000) $display("[TB] FAIL mid_rst_err: got %b want 000", {err_busy, err_pw, err_setup}); else passes++;
        @(negedge clk);
        e = 1'b0;
        nrst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset;
        test_write_data;
        test_read_busy;
        test_wrap;
        test_clear;
        test_write_while_busy;
        test_back_to_back;
        test_timing_errors;
        test_reset_mid;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
